violation_logger: RTL and testbench
===================================

# violation_logger

Buffers red-light violation events from the vehicle-matching stage of the traffic system and hands them one record at a time to the reporting side. Sits directly downstream of `TrafficSystem`, which emits one event per detected crossing with gap under 50 ticks, and replaces its unbounded `Violations` array. Each record carries a per-vehicle repeat-offender flag, and dropped events are counted.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `ID_W`, 5: vehicle id width, matching the `ans` output.
- `BOARD_W`, 3: board index width, values 0..4.
- `TIME_W`, 19: timestamp width, matching the `TimeCrossed` entry width.
- `REPEAT_TH`, 3: per-vehicle count at or above which a record is flagged.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-low. Active level is 0.
- `in_valid`  in  1: violation event strobe, one cycle per event.
- `in_id`  in  ID_W: vehicle id. A value of 0 means no vehicle.
- `in_board`  in  BOARD_W: board where the crossing completed.
- `in_time`  in  TIME_W: `mainClock` value at detection.
- `out_valid`  out  1: a head record is available.
- `out_ready`  in  1: consumer accepts the head record.
- `out_id`, `out_board`, `out_time`  out  ID_W/BOARD_W/TIME_W: head record fields.
- `out_repeat`  out  1: head record's vehicle had reached `REPEAT_TH` when the record was logged.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `drop_count`  out  8: events lost to overflow; saturates at 255.

## Operation
- **Push.** A push happens on a rising edge when all of these hold:
  - `in_valid`=1
  - `in_id`≠0
  - `in_board`≤4
  - either `count`<DEPTH, or `count`=DEPTH with a pop on the same edge
- **Illegal input.** An event with `in_id`=0 or `in_board`>4 is silently ignored. It does not change `drop_count`, `count` or the per-vehicle counters.
- **Overflow.** An otherwise legal event arriving when full with no pop increments `drop_count` (saturating). The FIFO and the per-vehicle counters are unchanged.
- **Per-vehicle counters.** There are 2^ID_W four-bit saturating counters.
  - On each push, `cnt[in_id]` increments, stopping at 15.
  - The stored `repeat` bit is 1 when (cnt_old+1) ≥ REPEAT_TH.
- **Pop.** A pop happens on a rising edge with `out_valid`=1 and `out_ready`=1. `out_ready` while empty has no effect.
- **Simultaneous push and pop.**
  - When full: both take effect and `count` stays at DEPTH.
  - When empty: only the push takes effect.
- **Pointers.** Read and write pointers wrap modulo DEPTH. `count` is tracked explicitly.

## Timing
- **Reset** (`reset`=0 at an edge), all after that edge:
  - `count`=0, `out_valid`=0, `drop_count`=0
  - all per-vehicle counters 0
  - `out_id`, `out_board`, `out_time`, `out_repeat` all 0
- **Reset has priority** over any same-edge push or pop. A reset mid-stream discards all buffered records.
- **Output latency.** A push at edge N into an empty FIFO gives `out_valid`=1 and valid fields after edge N, visible in cycle N+1.
- **Output stability.** `out_*` fields are registered. They only change after a pop, after a push into an empty FIFO, or at reset.
- **Valid/ready rule.** `out_valid` does not depend combinationally on `out_ready`.
- **Steady state.** One push and one pop per cycle are sustainable indefinitely.
- **Counter update.** `drop_count` and the per-vehicle counters update at the same edge as the triggering event.

## Structure
- **Shared package `traffic_pkg`:**
  - constants `ID_W`, `BOARD_W`, `TIME_W`, `NUM_BOARDS`=5
  - typedef `viol_rec_t` {id, board, time, repeat}
  - `TrafficSystem` and the light-board logic also take their widths from this package.
- **Sub-module `viol_fifo`:** a generic synchronous FIFO of `viol_rec_t`, with full/empty/count and a registered head.
- **Top level** holds the per-vehicle counter array, the input qualification and the drop counter.

## Test plan
1. **Reset:** hold `reset`=0 for 2 cycles while driving `in_valid`=1, `in_id`=7, `out_ready`=1 → `count`=0, `out_valid`=0, `drop_count`=0 throughout. First event after release → `count`=1.
2. **Single event:** push id=12, board=3, time=1000 with `out_ready`=0 → from the next cycle `out_valid`=1, `out_id`=12, `out_board`=3, `out_time`=1000, `out_repeat`=0. Raise `out_ready` for one cycle → `count`=0.
3. **Repeat offender:** push id=5 four times (REPEAT_TH=3) → popped `out_repeat` sequence 0,0,1,1. Then 20 more pushes of id=5 with continuous popping → no wrap, `out_repeat` stays 1.
4. **Overflow:** with `out_ready`=0, push 18 legal events → `count`=16, `drop_count`=2, and the popped order is events 1..16. Push 300 while full → `drop_count`=255.
5. **Full with same-edge pop:** at `count`=16, assert push and pop together → `count` stays 16, `drop_count` unchanged, new record appears last.
6. **Illegal inputs:** push id=0 (board 1), then board=6 (id 4) → `count`, `drop_count` and `cnt[4]` all unchanged.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared widths and record type for the traffic system datapath.
// Used by TrafficSystem, the light-board logic and the violation logger.
package traffic_pkg;

  localparam int unsigned ID_W       = 5;
  localparam int unsigned BOARD_W    = 3;
  localparam int unsigned TIME_W     = 19;
  localparam int unsigned NUM_BOARDS = 5;

  // One logged violation; rpt marks a vehicle at or past the repeat threshold.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BOARD_W-1:0] board;
    logic [TIME_W-1:0]  ts;
    logic               rpt;
  } viol_rec_t;

endpackage

// File: rtl/viol_fifo.sv
// Synchronous FIFO of viol_rec_t with a registered head record.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   push, wdata     : write request and record (ignored when full without pop)
//   pop             : consume head (ignored when empty)
//   head, head_valid: registered head record and its valid flag
//   full_c          : combinational full flag
//   count           : registered occupancy
module viol_fifo
  import traffic_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  viol_rec_t                wdata,
  input  logic                     pop,
  output viol_rec_t                head,
  output logic                     head_valid,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  viol_rec_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full_c      = (count == CNT_W'(DEPTH));
  assign pop_ok      = pop && head_valid;
  assign push_ok     = push && (!full_c || pop_ok);
  assign rd_next_ptr = rd_ptr + PTR_W'(1);

  // Storage needs no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_next_ptr;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // With more than one entry the successor is already in memory;
      // with exactly one, the successor can only be the same-edge write.
      if (pop_ok) begin
        if (count > CNT_W'(1)) begin
          head       <= mem[rd_next_ptr];
          head_valid <= 1'b1;
        end else if (push_ok) begin
          head       <= wdata;
          head_valid <= 1'b1;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (push_ok && !head_valid) begin
        head       <= wdata;
        head_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/violation_logger.sv
// Buffers red-light violation events and presents them one at a time.
// Qualifies input events, tracks per-vehicle repeat counts and counts
// events lost to overflow.
// Ports:
//   clk, reset                     : rising-edge clock, synchronous active-low reset
//   in_valid/in_id/in_board/in_time: incoming violation event
//   out_valid/out_ready            : head record handshake
//   out_id/out_board/out_time      : head record fields
//   out_repeat                     : vehicle had reached REPEAT_TH when logged
//   count                          : FIFO occupancy
//   drop_count                     : saturating count of overflow drops
module violation_logger #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ID_W      = traffic_pkg::ID_W,
  parameter int unsigned BOARD_W   = traffic_pkg::BOARD_W,
  parameter int unsigned TIME_W    = traffic_pkg::TIME_W,
  parameter int unsigned REPEAT_TH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ID_W-1:0]            in_id,
  input  logic [BOARD_W-1:0]         in_board,
  input  logic [TIME_W-1:0]          in_time,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [BOARD_W-1:0]         out_board,
  output logic [TIME_W-1:0]          out_time,
  output logic                       out_repeat,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_count
);

  localparam int unsigned NUM_IDS = 2 ** ID_W;

  traffic_pkg::viol_rec_t in_rec;
  traffic_pkg::viol_rec_t head;

  logic [3:0] vcnt [NUM_IDS];
  logic [4:0] vcnt_inc;
  logic       legal;
  logic       pop;
  logic       push;
  logic       drop;
  logic       full_c;

  // Event qualification: id 0 means no vehicle, boards beyond the last are bogus.
  assign legal    = in_valid && (in_id != '0) &&
                    (in_board < BOARD_W'(traffic_pkg::NUM_BOARDS));
  assign pop      = out_valid && out_ready;
  assign push     = legal && (!full_c || pop);
  assign drop     = legal && full_c && !pop;
  assign vcnt_inc = {1'b0, vcnt[in_id]} + 5'd1;

  always_comb begin
    in_rec       = '0;
    in_rec.id    = in_id;
    in_rec.board = in_board;
    in_rec.ts    = in_time;
    in_rec.rpt   = (vcnt_inc >= 5'(REPEAT_TH));
  end

  // Per-vehicle saturating push counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        vcnt[i] <= '0;
      end
    end else if (push && (vcnt[in_id] != 4'hF)) begin
      vcnt[in_id] <= vcnt_inc[3:0];
    end
  end

  // Saturating overflow drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  viol_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wdata      (in_rec),
    .pop        (pop),
    .head       (head),
    .head_valid (out_valid),
    .full_c     (full_c),
    .count      (count)
  );

  assign out_id     = head.id;
  assign out_board  = head.board;
  assign out_time   = head.ts;
  assign out_repeat = head.rpt;

endmodule

// File: tb/tb_violation_logger.sv
module tb_violation_logger;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_id;
  logic [2:0]  in_board;
  logic [18:0] in_time;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_id;
  logic [2:0]  out_board;
  logic [18:0] out_time;
  logic        out_repeat;
  logic [4:0]  count;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  violation_logger dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_id      (in_id),
    .in_board   (in_board),
    .in_time    (in_time),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_board  (out_board),
    .out_time   (out_time),
    .out_repeat (out_repeat),
    .count      (count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  id;
    logic [2:0]  b;
    logic [18:0] t;
    logic        rdy;
    int          ecnt;
    logic        evld;
    logic [4:0]  eid;
    logic [2:0]  eb;
    logic [18:0] et;
    logic        erpt;
    int          edrop;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic rst, input logic v, input int id, input int b,
                              input int t, input logic rdy, input int ecnt, input logic evld,
                              input int eid, input int eb, input int et, input logic erpt,
                              input int edrop);
    vec_t r;
    r.rst = rst; r.v = v; r.id = 5'(id); r.b = 3'(b); r.t = 19'(t); r.rdy = rdy;
    r.ecnt = ecnt; r.evld = evld; r.eid = 5'(eid); r.eb = 3'(eb); r.et = 19'(et);
    r.erpt = erpt; r.edrop = edrop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input int id, input int b,
                       input int t, input logic rdy);
    reset     = rst;
    in_valid  = v;
    in_id     = 5'(id);
    in_board  = 3'(b);
    in_time   = 19'(t);
    out_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int ev_id(input int i);
    return i + 1;
  endfunction
  function automatic int ev_b(input int i);
    return i % 5;
  endfunction
  function automatic int ev_t(input int i);
    return 200 + i;
  endfunction

  initial begin
    int e;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);

    // rst v id b t rdy | cnt vld id b t rpt drop
    vecs[0]  = mk(0, 1, 7, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);
    vecs[1]  = mk(0, 1, 7, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);
    vecs[2]  = mk(1, 1, 7, 2, 50,   0, 1, 1, 7, 2, 50,   0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);
    vecs[4]  = mk(1, 1, 12, 3, 1000, 0, 1, 1, 12, 3, 1000, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0,    0, 1, 1, 12, 3, 1000, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);
    vecs[7]  = mk(1, 1, 0, 1, 11,   0, 0, 0, 0, 0, 0,    0, 0);
    vecs[8]  = mk(1, 1, 4, 6, 12,   0, 0, 0, 0, 0, 0,    0, 0);
    vecs[9]  = mk(1, 1, 4, 5, 13,   0, 0, 0, 0, 0, 0,    0, 0);
    vecs[10] = mk(1, 1, 4, 4, 7,    0, 1, 1, 4, 4, 7,    0, 0);
    vecs[11] = mk(1, 1, 4, 0, 8,    0, 2, 1, 4, 4, 7,    0, 0);
    vecs[12] = mk(1, 1, 4, 1, 9,    1, 2, 1, 4, 0, 8,    0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0,    1, 1, 1, 4, 1, 9,    1, 0);
    vecs[14] = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0,    0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].v, int'(vecs[i].id), int'(vecs[i].b), int'(vecs[i].t),
            vecs[i].rdy);
      cyc();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].evld));
      chk($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(vecs[i].edrop));
      if (vecs[i].evld || !vecs[i].rst) begin
        chk($sformatf("vec%0d out_id", i), 32'(out_id), 32'(vecs[i].eid));
        chk($sformatf("vec%0d out_board", i), 32'(out_board), 32'(vecs[i].eb));
        chk($sformatf("vec%0d out_time", i), 32'(out_time), 32'(vecs[i].et));
        chk($sformatf("vec%0d out_repeat", i), 32'(out_repeat), 32'(vecs[i].erpt));
      end
    end

    // Repeat offender: four pushes of id 5, then drain.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 5, 0, k + 1, 0);
      cyc();
    end
    chk("rep count4", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rep%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("rep%0d id", k), 32'(out_id), 32'd5);
      chk($sformatf("rep%0d time", k), 32'(out_time), 32'(k + 1));
      chk($sformatf("rep%0d repeat", k), 32'(out_repeat), (k >= 2) ? 32'd1 : 32'd0);
      drive(1, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("rep drained", 32'(count), 32'd0);

    // Streaming with continuous pop; counter must saturate, not wrap.
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 5, 1, 100 + k, 1);
      cyc();
      chk($sformatf("stream%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d time", k), 32'(out_time), 32'(100 + k));
      chk($sformatf("stream%0d repeat", k), 32'(out_repeat), 32'd1);
      chk($sformatf("stream%0d count", k), 32'(count), 32'd1);
    end
    drive(1, 0, 0, 0, 0, 1);
    cyc();
    chk("stream drained", 32'(count), 32'd0);

    // Overflow: clear, then 18 pushes with no consumer.
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 1; i <= 18; i++) begin
      drive(1, 1, ev_id(i), ev_b(i), ev_t(i), 0);
      cyc();
    end
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf drop", 32'(drop_count), 32'd2);
    chk("ovf head id", 32'(out_id), 32'(ev_id(1)));
    chk("ovf head time", 32'(out_time), 32'(ev_t(1)));

    // Full with same-edge push and pop.
    drive(1, 1, ev_id(19), ev_b(19), ev_t(19), 1);
    cyc();
    chk("fullpp count", 32'(count), 32'd16);
    chk("fullpp drop", 32'(drop_count), 32'd2);
    chk("fullpp head id", 32'(out_id), 32'(ev_id(2)));

    // Drain: events 2..16 then 19.
    drive(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      e = (k < 15) ? k + 2 : 19;
      chk($sformatf("drain%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d id", k), 32'(out_id), 32'(ev_id(e)));
      chk($sformatf("drain%0d board", k), 32'(out_board), 32'(ev_b(e)));
      chk($sformatf("drain%0d time", k), 32'(out_time), 32'(ev_t(e)));
      chk($sformatf("drain%0d repeat", k), 32'(out_repeat), 32'd0);
      cyc();
    end
    chk("drain empty valid", 32'(out_valid), 32'd0);
    chk("drain empty count", 32'(count), 32'd0);

    // Refill and hammer while full: drop counter saturates.
    for (int i = 1; i <= 16; i++) begin
      drive(1, 1, ev_id(i), ev_b(i), ev_t(i), 0);
      cyc();
    end
    for (int k = 1; k <= 300; k++) begin
      drive(1, 1, 9, 2, 5000 + k, 0);
      cyc();
      if (k == 252) chk("drop 254", 32'(drop_count), 32'd254);
      if (k == 253) chk("drop 255", 32'(drop_count), 32'd255);
    end
    chk("drop sat", 32'(drop_count), 32'd255);
    chk("drop sat count", 32'(count), 32'd16);
    chk("drop sat head", 32'(out_id), 32'(ev_id(1)));

    // Reset mid-stream beats same-edge push and pop.
    drive(0, 1, 7, 1, 77, 1);
    cyc();
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst drop", 32'(drop_count), 32'd0);
    chk("midrst id", 32'(out_id), 32'd0);
    chk("midrst board", 32'(out_board), 32'd0);
    chk("midrst time", 32'(out_time), 32'd0);
    chk("midrst repeat", 32'(out_repeat), 32'd0);

    // Per-vehicle counter for id 3 was cleared by reset.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 3, 2, 300 + k, 0);
      cyc();
    end
    chk("post count", 32'(count), 32'd3);
    drive(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post%0d time", k), 32'(out_time), 32'(300 + k));
      chk($sformatf("post%0d repeat", k), 32'(out_repeat), (k == 2) ? 32'd1 : 32'd0);
      cyc();
    end
    chk("post empty", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
